// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture path: symbol codes,
// the active-high gfedcba segment table (common with the driver's encoder)
// and the capture FSM state type.
package seven_segment_pkg;

    // Symbol codes: 0-15 are hex digits
    localparam logic [4:0] SYM_BLANK   = 5'd16;
    localparam logic [4:0] SYM_MINUS   = 5'd17;
    localparam logic [4:0] SYM_INVALID = 5'd31;

    // Segment patterns, active-high, bit order g..a
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        HOLD
    } cap_state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational segment-pattern to symbol decoder. Any pattern outside the
// shared table maps to SYM_INVALID and raises 'invalid'.
module seven_segment_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] symbol,
    output logic       invalid
);

    // Table lookup of the active-high gfedcba pattern
    always_comb begin
        symbol = SYM_INVALID;
        case (pattern)
            SEG_0:     symbol = 5'd0;
            SEG_1:     symbol = 5'd1;
            SEG_2:     symbol = 5'd2;
            SEG_3:     symbol = 5'd3;
            SEG_4:     symbol = 5'd4;
            SEG_5:     symbol = 5'd5;
            SEG_6:     symbol = 5'd6;
            SEG_7:     symbol = 5'd7;
            SEG_8:     symbol = 5'd8;
            SEG_9:     symbol = 5'd9;
            SEG_A:     symbol = 5'd10;
            SEG_B:     symbol = 5'd11;
            SEG_C:     symbol = 5'd12;
            SEG_D:     symbol = 5'd13;
            SEG_E:     symbol = 5'd14;
            SEG_F:     symbol = 5'd15;
            SEG_MINUS: symbol = SYM_MINUS;
            SEG_BLANK: symbol = SYM_BLANK;
            default:   symbol = SYM_INVALID;
        endcase
        invalid = (symbol == SYM_INVALID);
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed seven-segment display: synchronises the
// anode/cathode lines, waits for each anode dwell to settle, decodes the
// digit and publishes a 4-digit frame with a one-cycle frame_valid strobe.
// Optional feature macro: SEVSEG_VALUE_EN adds a signed decimal parse of
// each frame on ports value / value_valid.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anodes,
    input  logic [7:0]  cathodes,
    output logic [19:0] symbols,
    output logic [3:0]  dp_mask,
    output logic        frame_valid,
    output logic        decode_error,
    output logic        anode_error
`ifdef SEVSEG_VALUE_EN
    ,
    output logic signed [7:0] value,
    output logic              value_valid
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]       an_meta, an_sync;
    logic [7:0]       cat_meta, cat_sync;

    cap_state_t       state, state_next;
    logic [3:0]       lat_pattern;
    logic [1:0]       lat_idx;
    logic [CNT_W-1:0] settle_cnt;

    logic             an_one_low, an_multi_low;
    logic [1:0]       an_idx;
    logic             eval_idle, load_digit, cnt_inc, anode_err_set, do_sample;

    logic [4:0]       dec_sym;
    logic             dec_invalid;

    logic [3:0][4:0]  shadow_sym;
    logic [3:0]       shadow_dp;
    logic [3:0]       seen;

    // Two-flop synchroniser for both line groups; idle level is all-high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_meta  <= '1;
            an_sync  <= '1;
            cat_meta <= '1;
            cat_sync <= '1;
        end else begin
            an_meta  <= anodes;
            an_sync  <= an_meta;
            cat_meta <= cathodes;
            cat_sync <= cat_meta;
        end
    end

    // Classify the synchronised anode pattern: none, exactly one, or several low
    always_comb begin
        an_one_low = 1'b1;
        an_idx     = 2'd0;
        case (an_sync)
            4'b1110: an_idx = 2'd0;
            4'b1101: an_idx = 2'd1;
            4'b1011: an_idx = 2'd2;
            4'b0111: an_idx = 2'd3;
            default: an_one_low = 1'b0;
        endcase
        an_multi_low = !an_one_low && (an_sync != 4'b1111);
    end

    // Capture FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and control; a broken settle falls through to the IDLE
    // evaluation in the same cycle so a new digit is latched immediately
    always_comb begin
        state_next    = state;
        eval_idle     = 1'b0;
        load_digit    = 1'b0;
        cnt_inc       = 1'b0;
        anode_err_set = 1'b0;
        do_sample     = 1'b0;
        unique case (state)
            IDLE: eval_idle = 1'b1;
            SETTLE: begin
                if (an_sync != lat_pattern)       eval_idle  = 1'b1;
                else if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
                else                              cnt_inc    = 1'b1;
            end
            SAMPLE: begin
                do_sample  = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (an_sync != lat_pattern) state_next = IDLE;
            end
        endcase
        if (eval_idle) begin
            state_next = IDLE;
            if (an_one_low) begin
                load_digit = 1'b1;
                state_next = SETTLE;
            end else if (an_multi_low) begin
                anode_err_set = 1'b1;
            end
        end
    end

    // Latched digit pattern/index and settle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_pattern <= '1;
            lat_idx     <= '0;
            settle_cnt  <= '0;
        end else if (load_digit) begin
            lat_pattern <= an_sync;
            lat_idx     <= an_idx;
            settle_cnt  <= '0;
        end else if (cnt_inc) begin
            settle_cnt  <= settle_cnt + 1'b1;
        end
    end

    seven_segment_decoder u_decoder (
        .pattern (~cat_sync[6:0]),
        .symbol  (dec_sym),
        .invalid (dec_invalid)
    );

    // Sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_error  <= 1'b0;
            decode_error <= 1'b0;
        end else begin
            if (anode_err_set)            anode_error  <= 1'b1;
            if (do_sample && dec_invalid) decode_error <= 1'b1;
        end
    end

    // Shadow frame fill and publication one cycle after all four digits are seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_sym  <= {4{SYM_BLANK}};
            shadow_dp   <= '0;
            seen        <= '0;
            symbols     <= {4{SYM_BLANK}};
            dp_mask     <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (do_sample) begin
                shadow_sym[lat_idx] <= dec_sym;
                shadow_dp[lat_idx]  <= ~cat_sync[7];
                seen[lat_idx]       <= 1'b1;
            end
            if (seen == 4'b1111) begin
                symbols     <= shadow_sym;
                dp_mask     <= shadow_dp;
                frame_valid <= 1'b1;
                seen        <= '0;
            end
        end
    end

`ifdef SEVSEG_VALUE_EN
    logic        parse_started, parse_neg, parse_digit, parse_ok, parse_in_range;
    logic [13:0] parse_mag;
    logic [4:0]  parse_sym;

    // Decimal parse of the shadow frame, leftmost digit first
    always_comb begin
        parse_started = 1'b0;
        parse_neg     = 1'b0;
        parse_digit   = 1'b0;
        parse_ok      = 1'b1;
        parse_mag     = '0;
        parse_sym     = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            parse_sym = shadow_sym[2'(3 - k)];
            if (!parse_started) begin
                if (parse_sym == SYM_BLANK) begin
                    parse_started = 1'b0;
                end else if (parse_sym == SYM_MINUS) begin
                    parse_started = 1'b1;
                    parse_neg     = 1'b1;
                end else if (parse_sym < 5'd10) begin
                    parse_started = 1'b1;
                    parse_digit   = 1'b1;
                    parse_mag     = 14'(parse_sym);
                end else begin
                    parse_ok = 1'b0;
                end
            end else if (parse_sym < 5'd10) begin
                parse_digit = 1'b1;
                parse_mag   = parse_mag * 14'd10 + 14'(parse_sym);
            end else begin
                parse_ok = 1'b0;
            end
        end
        parse_in_range = parse_neg ? (parse_mag <= 14'd128) : (parse_mag <= 14'd127);
    end

    // Parsed value register, refreshed together with the frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value       <= '0;
            value_valid <= 1'b0;
        end else if (seen == 4'b1111) begin
            if (parse_ok && parse_digit && parse_in_range) begin
                value       <= 8'(parse_neg ? (14'd0 - parse_mag) : parse_mag);
                value_valid <= 1'b1;
            end else begin
                value       <= '0;
                value_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
